// File: rtl/tdpram32_port_arb_if.sv
// Request/acknowledge bundle for one master of the port-B arbiter.
// The master drives the request fields; the arbiter returns ack and read data.
interface tdpram32_port_arb_if #(
  parameter int ADDR_WIDTH = 13
);
  logic                  req;
  logic                  we;
  logic [3:0]            byte_en;
  logic [ADDR_WIDTH-1:0] addr;
  logic [31:0]           wdata;
  logic                  ack;
  logic [31:0]           rdata;

  modport master (
    output req, we, byte_en, addr, wdata,
    input  ack, rdata
  );

  modport slave (
    input  req, we, byte_en, addr, wdata,
    output ack, rdata
  );
endinterface

// File: rtl/tdpram32_port_arb.sv
// Round-robin arbiter for two masters sharing port B of the 32-bit dual-port RAM.
// Define TDPRAM32_PORT_ARB_CLEAR_EN to zero-fill the RAM after every reset.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_CLEAR | writing zero to address clr_cnt, requests ignored, busy=1
// S_RUN   | arbitrating m0/m1, one RAM access per cycle at most
module tdpram32_port_arb #(
  parameter int ADDR_WIDTH = 13
) (
  input  logic                  clk,
  input  logic                  rst,
  tdpram32_port_arb_if.slave    m0,
  tdpram32_port_arb_if.slave    m1,
  output logic                  ram_we,
  output logic [3:0]            ram_byte_en,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [31:0]           ram_wdata,
  input  logic [31:0]           ram_rdata,
  output logic                  busy
);

  logic                  ack0_q;
  logic                  ack1_q;
  logic                  rr_last;
  logic                  run;
  logic                  clearing;
  logic [ADDR_WIDTH-1:0] clr_addr;
  logic                  elig0;
  logic                  elig1;
  logic                  gnt0;
  logic                  gnt1;

`ifdef TDPRAM32_PORT_ARB_CLEAR_EN
  typedef enum logic {
    S_CLEAR,
    S_RUN
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] clr_cnt;
  logic                  busy_q;

  assign run      = (state == S_RUN);
  assign clearing = (state == S_CLEAR);
  assign clr_addr = clr_cnt;
  assign busy     = busy_q;
`else
  assign run      = 1'b1;
  assign clearing = 1'b0;
  assign clr_addr = '0;
  assign busy     = 1'b0;
`endif

  // A registered ack marks the master granted last cycle, so it doubles as
  // the pending-grant flag that makes that master ineligible this cycle.
  always_comb begin
    elig0 = run && m0.req && !ack0_q;
    elig1 = run && m1.req && !ack1_q;
    gnt0  = elig0 && (!elig1 || rr_last);
    gnt1  = elig1 && (!elig0 || !rr_last);
  end

  always_comb begin
    ram_we      = 1'b0;
    ram_byte_en = 4'h0;
    ram_addr    = '0;
    ram_wdata   = '0;
    if (clearing) begin
      ram_we      = 1'b1;
      ram_byte_en = 4'hF;
      ram_addr    = clr_addr;
    end else if (gnt0) begin
      ram_we      = m0.we;
      ram_byte_en = m0.we ? m0.byte_en : 4'h0;
      ram_addr    = m0.addr;
      ram_wdata   = m0.wdata;
    end else if (gnt1) begin
      ram_we      = m1.we;
      ram_byte_en = m1.we ? m1.byte_en : 4'h0;
      ram_addr    = m1.addr;
      ram_wdata   = m1.wdata;
    end
  end

  // rr_last=1 means m1 was granted most recently; reset value favours m0.
  always_ff @(posedge clk) begin
    if (rst) begin
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      rr_last <= 1'b1;
`ifdef TDPRAM32_PORT_ARB_CLEAR_EN
      state   <= S_CLEAR;
      clr_cnt <= '0;
      busy_q  <= 1'b1;
`endif
    end else begin
      ack0_q <= gnt0;
      ack1_q <= gnt1;
      if (gnt0) begin
        rr_last <= 1'b0;
      end else if (gnt1) begin
        rr_last <= 1'b1;
      end
`ifdef TDPRAM32_PORT_ARB_CLEAR_EN
      if (state == S_CLEAR) begin
        clr_cnt <= clr_cnt + 1'b1;
        if (&clr_cnt) begin
          state  <= S_RUN;
          busy_q <= 1'b0;
        end
      end
`endif
    end
  end

  assign m0.ack   = ack0_q;
  assign m1.ack   = ack1_q;
  assign m0.rdata = ram_rdata;
  assign m1.rdata = ram_rdata;

endmodule

// File: tb/tb_tdpram32_port_arb.sv
// Directed bench for tdpram32_port_arb with a behavioural port-B RAM model.
// Clear-sequence checks are compiled only with TDPRAM32_PORT_ARB_CLEAR_EN.
module tb_tdpram32_port_arb;
  localparam int AW = 4;

  logic          clk;
  logic          rst;
  logic          ram_we;
  logic [3:0]    ram_byte_en;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_wdata;
  logic [31:0]   ram_rdata;
  logic          busy;
  logic [31:0]   mem [16];

  int n_chk  = 0;
  int n_pass = 0;

  tdpram32_port_arb_if #(.ADDR_WIDTH(AW)) m0_if ();
  tdpram32_port_arb_if #(.ADDR_WIDTH(AW)) m1_if ();

  tdpram32_port_arb #(.ADDR_WIDTH(AW)) dut (
    .clk         (clk),
    .rst         (rst),
    .m0          (m0_if),
    .m1          (m1_if),
    .ram_we      (ram_we),
    .ram_byte_en (ram_byte_en),
    .ram_addr    (ram_addr),
    .ram_wdata   (ram_wdata),
    .ram_rdata   (ram_rdata),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Port-B RAM: registered read, byte-masked write.
  always @(posedge clk) begin
    if (ram_we) begin
      for (int b = 0; b < 4; b++) begin
        if (ram_byte_en[b]) mem[ram_addr][b*8 +: 8] <= ram_wdata[b*8 +: 8];
      end
    end
    ram_rdata <= mem[ram_addr];
  end

  typedef struct {
    logic        r0;
    logic        w0;
    logic [3:0]  b0;
    logic [3:0]  a0;
    logic [31:0] d0;
    logic        r1;
    logic        w1;
    logic [3:0]  b1;
    logic [3:0]  a1;
    logic [31:0] d1;
    logic        e_we;
    logic [3:0]  e_be;
    logic [3:0]  e_addr;
    logic [31:0] e_wd;
    logic        e_ack0;
    logic        e_ack1;
    logic        c_rd;
    logic [31:0] e_rd;
  } vec_t;

  vec_t vt [18];

  function automatic vec_t mk(
    input logic r0, input logic w0, input logic [3:0] b0, input logic [3:0] a0, input logic [31:0] d0,
    input logic r1, input logic w1, input logic [3:0] b1, input logic [3:0] a1, input logic [31:0] d1,
    input logic e_we, input logic [3:0] e_be, input logic [3:0] e_addr, input logic [31:0] e_wd,
    input logic e_ack0, input logic e_ack1, input logic c_rd, input logic [31:0] e_rd);
    vec_t v;
    v.r0 = r0; v.w0 = w0; v.b0 = b0; v.a0 = a0; v.d0 = d0;
    v.r1 = r1; v.w1 = w1; v.b1 = b1; v.a1 = a1; v.d1 = d1;
    v.e_we = e_we; v.e_be = e_be; v.e_addr = e_addr; v.e_wd = e_wd;
    v.e_ack0 = e_ack0; v.e_ack1 = e_ack1; v.c_rd = c_rd; v.e_rd = e_rd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
  endtask

  task automatic set_m0(input logic r, input logic w, input logic [3:0] b, input logic [3:0] a, input logic [31:0] d);
    m0_if.req = r; m0_if.we = w; m0_if.byte_en = b; m0_if.addr = a; m0_if.wdata = d;
  endtask

  task automatic set_m1(input logic r, input logic w, input logic [3:0] b, input logic [3:0] a, input logic [31:0] d);
    m1_if.req = r; m1_if.we = w; m1_if.byte_en = b; m1_if.addr = a; m1_if.wdata = d;
  endtask

  task automatic chk_ram(input string tag, input logic we, input logic [3:0] be, input logic [3:0] a, input logic [31:0] wd);
    chk({tag, " ram_we"}, ram_we, we);
    chk({tag, " ram_byte_en"}, ram_byte_en, be);
    chk({tag, " ram_addr"}, ram_addr, a);
    chk({tag, " ram_wdata"}, ram_wdata, wd);
  endtask

  // Holds rst for two edges and checks the reset state; rst is left high.
  task automatic reset_phase();
    rst = 1'b1;
    set_m0(0, 0, 4'h0, 4'h0, 32'h0);
    set_m1(0, 0, 4'h0, 4'h0, 32'h0);
    repeat (2) @(negedge clk);
    #1;
    chk("reset m0_ack", m0_if.ack, 1'b0);
    chk("reset m1_ack", m1_if.ack, 1'b0);
`ifdef TDPRAM32_PORT_ARB_CLEAR_EN
    chk("reset busy", busy, 1'b1);
`else
    chk("reset busy", busy, 1'b0);
`endif
  endtask

`ifdef TDPRAM32_PORT_ARB_CLEAR_EN
  // Requests are held high during the clear to prove they are ignored.
  task automatic clear_steps(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst = 1'b0;
      set_m0(1, 0, 4'h0, 4'h0, 32'h0);
      set_m1(1, 0, 4'h0, 4'h0, 32'h0);
      #1;
      chk("clear busy", busy, 1'b1);
      chk_ram("clear", 1'b1, 4'hF, i[3:0], 32'h0);
      chk("clear m0_ack", m0_if.ack, 1'b0);
      chk("clear m1_ack", m1_if.ack, 1'b0);
    end
  endtask
`endif

  initial begin
    int k;
    for (int i = 0; i < 16; i++) begin
`ifdef TDPRAM32_PORT_ARB_CLEAR_EN
      mem[i] = 32'hA5A5A5A5;
`else
      mem[i] = 32'h0;
`endif
    end

    //        r0 w0 b0    a0    d0             r1 w1 b1    a1    d1             we be    addr  wdata          a0 a1 crd rdata
    vt[0]  = mk(1, 1, 4'hF, 4'd1, 32'h00001111, 1, 1, 4'hF, 4'd2, 32'h22220000, 1, 4'hF, 4'd1, 32'h00001111, 0, 0, 0, 32'h0);
    vt[1]  = mk(1, 1, 4'hF, 4'd1, 32'h00001111, 1, 1, 4'hF, 4'd2, 32'h22220000, 1, 4'hF, 4'd2, 32'h22220000, 1, 0, 0, 32'h0);
    vt[2]  = mk(1, 1, 4'hF, 4'd3, 32'hDEADBEEF, 1, 1, 4'hF, 4'd2, 32'h22220000, 1, 4'hF, 4'd3, 32'hDEADBEEF, 0, 1, 0, 32'h0);
    vt[3]  = mk(1, 1, 4'hF, 4'd3, 32'hDEADBEEF, 1, 1, 4'h5, 4'd4, 32'h11223344, 1, 4'h5, 4'd4, 32'h11223344, 1, 0, 0, 32'h0);
    vt[4]  = mk(1, 0, 4'hF, 4'd3, 32'hCAFEF00D, 1, 1, 4'h5, 4'd4, 32'h11223344, 0, 4'h0, 4'd3, 32'hCAFEF00D, 0, 1, 0, 32'h0);
    vt[5]  = mk(1, 0, 4'hF, 4'd3, 32'hCAFEF00D, 1, 0, 4'hF, 4'd4, 32'h00000000, 0, 4'h0, 4'd4, 32'h00000000, 1, 0, 1, 32'hDEADBEEF);
    vt[6]  = mk(0, 0, 4'h0, 4'd0, 32'h00000000, 1, 0, 4'hF, 4'd4, 32'h00000000, 0, 4'h0, 4'd0, 32'h00000000, 0, 1, 1, 32'h00220044);
    vt[7]  = mk(0, 0, 4'h0, 4'd0, 32'h00000000, 0, 0, 4'h0, 4'd0, 32'h00000000, 0, 4'h0, 4'd0, 32'h00000000, 0, 0, 0, 32'h0);
    vt[8]  = mk(1, 0, 4'h0, 4'd1, 32'h00000000, 0, 0, 4'h0, 4'd0, 32'h00000000, 0, 4'h0, 4'd1, 32'h00000000, 0, 0, 0, 32'h0);
    vt[9]  = mk(1, 0, 4'h0, 4'd1, 32'h00000000, 0, 0, 4'h0, 4'd0, 32'h00000000, 0, 4'h0, 4'd0, 32'h00000000, 1, 0, 1, 32'h00001111);
    vt[10] = mk(1, 0, 4'h0, 4'd2, 32'h00000000, 1, 0, 4'h0, 4'd3, 32'h00000000, 0, 4'h0, 4'd3, 32'h00000000, 0, 0, 0, 32'h0);
    vt[11] = mk(1, 0, 4'h0, 4'd2, 32'h00000000, 1, 0, 4'h0, 4'd3, 32'h00000000, 0, 4'h0, 4'd2, 32'h00000000, 0, 1, 1, 32'hDEADBEEF);
    vt[12] = mk(1, 0, 4'h0, 4'd2, 32'h00000000, 0, 0, 4'h0, 4'd0, 32'h00000000, 0, 4'h0, 4'd0, 32'h00000000, 1, 0, 1, 32'h22220000);
    vt[13] = mk(1, 1, 4'hA, 4'd5, 32'h55AA55AA, 0, 0, 4'h0, 4'd0, 32'h00000000, 1, 4'hA, 4'd5, 32'h55AA55AA, 0, 0, 0, 32'h0);
    vt[14] = mk(0, 0, 4'h0, 4'd0, 32'h00000000, 0, 0, 4'h0, 4'd0, 32'h00000000, 0, 4'h0, 4'd0, 32'h00000000, 1, 0, 0, 32'h0);
    vt[15] = mk(0, 0, 4'h0, 4'd0, 32'h00000000, 0, 0, 4'h0, 4'd0, 32'h00000000, 0, 4'h0, 4'd0, 32'h00000000, 0, 0, 0, 32'h0);
    vt[16] = mk(0, 0, 4'h0, 4'd0, 32'h00000000, 1, 0, 4'hF, 4'd5, 32'h00000000, 0, 4'h0, 4'd5, 32'h00000000, 0, 0, 0, 32'h0);
    vt[17] = mk(0, 0, 4'h0, 4'd0, 32'h00000000, 0, 0, 4'h0, 4'd0, 32'h00000000, 0, 4'h0, 4'd0, 32'h00000000, 0, 1, 1, 32'h55005500);

    reset_phase();

`ifdef TDPRAM32_PORT_ARB_CLEAR_EN
    // Reset while the clear counter is 7, then a full 16-cycle clear.
    clear_steps(7);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midclear addr", ram_addr, 4'd7);
    clear_steps(16);

    // Every word reads back as zero.
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      set_m0(1, 0, 4'hF, i[3:0], 32'h0);
      set_m1(0, 0, 4'h0, 4'h0, 32'h0);
      #1;
      chk("readback busy", busy, 1'b0);
      chk("readback addr", ram_addr, i[3:0]);
      @(negedge clk);
      set_m0(0, 0, 4'h0, 4'h0, 32'h0);
      #1;
      chk("readback ack", m0_if.ack, 1'b1);
      chk("readback rdata", m0_if.rdata, 32'h0);
    end

    reset_phase();
    clear_steps(16);
`endif

    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      rst = 1'b0;
      set_m0(vt[i].r0, vt[i].w0, vt[i].b0, vt[i].a0, vt[i].d0);
      set_m1(vt[i].r1, vt[i].w1, vt[i].b1, vt[i].a1, vt[i].d1);
      #1;
      chk_ram($sformatf("vec%0d", i), vt[i].e_we, vt[i].e_be, vt[i].e_addr, vt[i].e_wd);
      chk($sformatf("vec%0d m0_ack", i), m0_if.ack, vt[i].e_ack0);
      chk($sformatf("vec%0d m1_ack", i), m1_if.ack, vt[i].e_ack1);
      chk($sformatf("vec%0d busy", i), busy, 1'b0);
      if (vt[i].c_rd) begin
        chk($sformatf("vec%0d m0_rdata", i), m0_if.rdata, vt[i].e_rd);
        chk($sformatf("vec%0d m1_rdata", i), m1_if.rdata, vt[i].e_rd);
      end
    end

    // Reset in m0's read grant cycle: the following ack is suppressed.
    @(negedge clk);
    rst = 1'b1;
    set_m0(1, 0, 4'h0, 4'd3, 32'h0);
    set_m1(0, 0, 4'h0, 4'h0, 32'h0);
    #1;
    chk("rstacc grant addr", ram_addr, 4'd3);
    chk("rstacc grant we", ram_we, 1'b0);
    k = 0;
    do begin
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rstacc m0_ack suppressed", m0_if.ack, 1'b0);
      k++;
    end while (busy && k < 40);
    chk("rstacc busy released", busy, 1'b0);
    chk("rstacc regrant addr", ram_addr, 4'd3);
    @(negedge clk);
    set_m0(0, 0, 4'h0, 4'h0, 32'h0);
    #1;
    chk("rstacc m0_ack", m0_if.ack, 1'b1);
`ifdef TDPRAM32_PORT_ARB_CLEAR_EN
    chk("rstacc m0_rdata", m0_if.rdata, 32'h0);
`else
    chk("rstacc m0_rdata", m0_if.rdata, 32'hDEADBEEF);
`endif
    @(negedge clk);
    #1;
    chk("rstacc ack done", m0_if.ack, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
